ysyx_23060025_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the IFU stage's fetch port (`out_paddr`/`out_psel`/`out_pready`/`out_prdata`) and the instruction memory AXI read channel. It accepts one fetch request per `psel` pulse and returns the 32-bit instruction word with a one-cycle `pready` pulse. Misses are refilled with one INCR burst of a full line. Whole-cache invalidation is triggered by `fence.i` from WB.

---
 rtl/ysyx_23060025_icache_if.sv | 28 ++
 rtl/ysyx_23060025_icache.sv | 159 +++++++++++++++
 tb/tb_ysyx_23060025_icache.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_icache_if.sv
// AXI read-channel bundle between the instruction cache (master) and
// instruction memory (slave).
interface ysyx_23060025_icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, arlen, arsize, arburst, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arvalid, arlen, arsize, arburst, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache with flop storage and
// whole-line INCR burst refill over an AXI read channel.
module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ifu_paddr_i,
    input  logic                  ifu_psel_i,
    output logic                  ifu_pready_o,
    output logic [DATA_WIDTH-1:0] ifu_prdata_o,
    input  logic                  fencei_inv_i,
    ysyx_23060025_icache_if.master mem
);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - BYTE_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, RESP} state_t;

    state_t                state_q, state_d;
    logic                  pend_q, redirect_q, inv_seen_q, err_q;
    logic [OFF_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [DATA_WIDTH-1:0] buf_q [LINE_WORDS];

    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic [IDX_W-1:0]      req_idx, fill_idx;
    logic [OFF_W-1:0]      req_off;
    logic                  hit, start_fill, beat, fill_done;
    logic [DATA_WIDTH-1:0] fill_line [LINE_WORDS];
    logic                  unused_ok;

    assign req_tag   = ifu_paddr_i[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx   = ifu_paddr_i[BYTE_W+OFF_W +: IDX_W];
    assign req_off   = ifu_paddr_i[BYTE_W +: OFF_W];
    assign fill_tag  = line_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx  = line_addr_q[BYTE_W+OFF_W +: IDX_W];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign beat      = (state_q == MISS_R) && mem.rvalid;
    assign fill_done = beat && mem.rlast;
    assign unused_ok = &{1'b0, ifu_paddr_i[BYTE_W-1:0]};

    // The last beat bypasses the refill buffer so the line is written whole.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_fill
        assign fill_line[gi] = (cnt_q == OFF_W'(gi)) ? mem.rdata : buf_q[gi];
    end

    assign mem.araddr  = line_addr_q;
    assign mem.arvalid = (state_q == MISS_AR);
    assign mem.rready  = (state_q == MISS_R);
    assign mem.arlen   = 8'(LINE_WORDS - 1);
    assign mem.arsize  = 3'b010;
    assign mem.arburst = 2'b01;

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        start_fill   = 1'b0;
        ifu_pready_o = 1'b0;
        ifu_prdata_o = '0;
        case (state_q)
            IDLE: begin
                if (ifu_psel_i) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    ifu_pready_o = pend_q;
                    ifu_prdata_o = pend_q ? data_q[req_idx][req_off] : '0;
                    state_d      = ifu_psel_i ? LOOKUP : IDLE;
                end else if (ifu_psel_i) begin
                    // Request superseded by a redirect: drop it without refilling.
                    state_d = LOOKUP;
                end else begin
                    line_addr_d = {ifu_paddr_i[ADDR_WIDTH-1:BYTE_W+OFF_W], {(BYTE_W+OFF_W){1'b0}}};
                    start_fill  = 1'b1;
                    state_d     = MISS_AR;
                end
            end
            MISS_AR: begin
                if (mem.arready) state_d = MISS_R;
            end
            MISS_R: begin
                if (fill_done) state_d = RESP;
            end
            RESP: begin
                if (redirect_q || ifu_psel_i) begin
                    state_d = LOOKUP;
                end else begin
                    ifu_pready_o = 1'b1;
                    ifu_prdata_o = buf_q[req_off];
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            redirect_q  <= 1'b0;
            inv_seen_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            line_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            if (ifu_psel_i)        pend_q <= 1'b1;
            else if (ifu_pready_o) pend_q <= 1'b0;

            if (start_fill || state_q == RESP)
                redirect_q <= 1'b0;
            else if (ifu_psel_i && (state_q == MISS_AR || state_q == MISS_R))
                redirect_q <= 1'b1;

            if (start_fill)
                inv_seen_q <= 1'b0;
            else if (fencei_inv_i && (state_q == MISS_AR || state_q == MISS_R))
                inv_seen_q <= 1'b1;

            if (start_fill) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
                if (mem.rresp != 2'b00) err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (beat) buf_q[cnt_q] <= mem.rdata;
    end

    // Invalidate is applied last so it overrides a same-cycle line install.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (fill_done) begin
                tag_q[fill_idx]   <= fill_tag;
                data_q[fill_idx]  <= fill_line;
                valid_q[fill_idx] <= !(err_q || (mem.rresp != 2'b00) || inv_seen_q);
            end
            if (fencei_inv_i) valid_q <= '0;
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed bench for the instruction cache: hits, misses, eviction, redirect,
// fence.i, error responses and mid-burst reset.
module tb_ysyx_23060025_icache;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] paddr = 32'h0;
    logic        psel  = 1'b0;
    logic        pready;
    logic [31:0] prdata;
    logic        fencei = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    ysyx_23060025_icache_if mem_if ();

    ysyx_23060025_icache dut (
        .clock        (clock),
        .reset        (reset),
        .ifu_paddr_i  (paddr),
        .ifu_psel_i   (psel),
        .ifu_pready_o (pready),
        .ifu_prdata_o (prdata),
        .fencei_inv_i (fencei),
        .mem          (mem_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a);
        psel = 1'b1;
        tick();
        psel  = 1'b0;
        paddr = a;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] exp);
        #2;
        check({tag, "_pready"}, 32'(pready), 32'd1);
        check({tag, "_data"}, prdata, exp);
        check({tag, "_no_ar"}, 32'(mem_if.arvalid), 32'd0);
        tick();
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp);
        #2;
        check({tag, "_resp_pready"}, 32'(pready), 32'd1);
        check({tag, "_resp_data"}, prdata, exp);
        tick();
    endtask

    // Entered in the LOOKUP cycle of a missing fetch; returns in the RESP cycle.
    task automatic serve_miss(input string tag, input logic [31:0] line, input logic [127:0] words,
                              input int err_beat, input int fence_beat, input int redir_beat,
                              input logic [31:0] redir_addr, input int ar_wait);
        #2;
        check({tag, "_lookup_pready"}, 32'(pready), 32'd0);
        check({tag, "_lookup_arvalid"}, 32'(mem_if.arvalid), 32'd0);
        tick();
        for (int w = 0; w <= ar_wait; w++) begin
            mem_if.arready = (w == ar_wait);
            #2;
            check({tag, "_arvalid"}, 32'(mem_if.arvalid), 32'd1);
            check({tag, "_araddr"}, mem_if.araddr, line);
            check({tag, "_rready_in_ar"}, 32'(mem_if.rready), 32'd0);
            tick();
        end
        mem_if.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = words[32*b +: 32];
            mem_if.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            mem_if.rlast  = (b == 3);
            fencei        = (b == fence_beat);
            psel          = (b == redir_beat);
            if (redir_beat >= 0 && b == redir_beat + 1) paddr = redir_addr;
            #2;
            check({tag, "_rready"}, 32'(mem_if.rready), 32'd1);
            check({tag, "_burst_pready"}, 32'(pready), 32'd0);
            check({tag, "_burst_arvalid"}, 32'(mem_if.arvalid), 32'd0);
            tick();
        end
        mem_if.rvalid = 1'b0;
        mem_if.rlast  = 1'b0;
        mem_if.rresp  = 2'b00;
        fencei        = 1'b0;
        psel          = 1'b0;
        if (redir_beat == 3) paddr = redir_addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        mem_if.arready = 1'b0;
        mem_if.rvalid  = 1'b0;
        mem_if.rlast   = 1'b0;
        mem_if.rresp   = 2'b00;
        mem_if.rdata   = 32'h0;

        tick();
        tick();
        reset = 1'b0;
        #2;
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_arvalid", 32'(mem_if.arvalid), 32'd0);
        check("rst_rready", 32'(mem_if.rready), 32'd0);
        check("rst_araddr", mem_if.araddr, 32'd0);
        check("arlen", 32'(mem_if.arlen), 32'd3);
        check("arsize", 32'(mem_if.arsize), 32'd2);
        check("arburst", 32'(mem_if.arburst), 32'd1);
        tick();

        // Cold miss, then a hit on the same line
        req(32'h8000_0004);
        serve_miss("cold", 32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1, -1, -1, 32'h0, 0);
        expect_resp("cold", 32'h22);
        $display("cold miss 0x80000004 done");
        req(32'h8000_000C);
        expect_hit("hit_0c", 32'h44);
        $display("hit 0x8000000C done");

        // Streaming hits, one word per cycle
        psel = 1'b1;
        tick();
        paddr = 32'h8000_0000; psel = 1'b1; expect_hit("stream0", 32'h11);
        paddr = 32'h8000_0004; psel = 1'b1; expect_hit("stream1", 32'h22);
        paddr = 32'h8000_0008; psel = 1'b1; expect_hit("stream2", 32'h33);
        paddr = 32'h8000_000C; psel = 1'b0; expect_hit("stream3", 32'h44);
        #2;
        check("stream_idle_pready", 32'(pready), 32'd0);
        tick();
        $display("streaming hits done");

        // Conflict eviction with a slow AR handshake
        req(32'h8000_0100);
        serve_miss("evict", 32'h8000_0100, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, -1, -1, -1, 32'h0, 2);
        expect_resp("evict", 32'hC0);
        req(32'h8000_0000);
        serve_miss("refetch", 32'h8000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, -1, -1, -1, 32'h0, 0);
        expect_resp("refetch", 32'h11);
        $display("conflict eviction done");

        // fence.i while idle, then redirect during the resulting refill
        fencei = 1'b1;
        tick();
        fencei = 1'b0;
        req(32'h8000_0000);
        serve_miss("redir_a", 32'h8000_0000, {32'h64, 32'h63, 32'h62, 32'h61}, -1, -1, 1, 32'h8000_0010, 0);
        #2;
        check("redir_no_pready", 32'(pready), 32'd0);
        tick();
        serve_miss("redir_b", 32'h8000_0010, {32'h58, 32'h57, 32'h56, 32'h55}, -1, -1, -1, 32'h0, 0);
        expect_resp("redir_b", 32'h55);
        req(32'h8000_0008);
        expect_hit("line0_valid", 32'h63);
        $display("fence idle + redirect done");

        // fence.i during refill: delivered once, line left invalid
        req(32'h8000_0024);
        serve_miss("fence_r", 32'h8000_0020, {32'h74, 32'h73, 32'h72, 32'h71}, -1, 2, -1, 32'h0, 0);
        expect_resp("fence_r", 32'h72);
        req(32'h8000_0024);
        serve_miss("fence_re", 32'h8000_0020, {32'h84, 32'h83, 32'h82, 32'h81}, -1, -1, -1, 32'h0, 0);
        expect_resp("fence_re", 32'h82);
        $display("fence during refill done");

        // Error response: delivered once, line left invalid
        req(32'h8000_0030);
        serve_miss("err", 32'h8000_0030, {32'h94, 32'h93, 32'h92, 32'h91}, 1, -1, -1, 32'h0, 0);
        expect_resp("err", 32'h91);
        req(32'h8000_0030);
        serve_miss("err_re", 32'h8000_0030, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, -1, -1, -1, 32'h0, 0);
        expect_resp("err_re", 32'hA1);
        req(32'h8000_0034);
        expect_hit("err_line_ok", 32'hA2);
        $display("error response done");

        // Reset in the middle of a burst
        req(32'h8000_0040);
        #2;
        check("rstm_lookup_pready", 32'(pready), 32'd0);
        tick();
        mem_if.arready = 1'b1;
        #2;
        check("rstm_arvalid", 32'(mem_if.arvalid), 32'd1);
        tick();
        mem_if.arready = 1'b0;
        mem_if.rvalid  = 1'b1;
        mem_if.rdata   = 32'hDEAD_0001;
        #2;
        check("rstm_rready", 32'(mem_if.rready), 32'd1);
        tick();
        mem_if.rvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check("rstm_after_rready", 32'(mem_if.rready), 32'd0);
        check("rstm_after_arvalid", 32'(mem_if.arvalid), 32'd0);
        check("rstm_after_pready", 32'(pready), 32'd0);
        tick();
        req(32'h8000_0034);
        serve_miss("rstm_inv", 32'h8000_0030, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, -1, -1, -1, 32'h0, 0);
        expect_resp("rstm_inv", 32'hB2);
        $display("reset mid-burst done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
